mvm_requant_serializer: RTL and testbench

- Downstream stage of the 4x4 systolic MVM array. Captures the four 64-bit row results (out1..out4) when the array signals done.
- Adds a per-row bias, rescales from Q(2F) product format to Q(F) data format, and saturates to DATA_WIDTH.
- Streams the four results one per handshake to the activation unit over a valid/ready interface.
- Flags overruns when the array finishes again before the previous vector has drained.

---
 rtl/mvm_requant_serializer.sv | 194 +++++++++++++++++++
 tb/tb_mvm_requant_serializer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_requant_serializer.sv
// mvm_requant_serializer
// Captures the four 64-bit row results of the 4x4 MVM array on the rising edge
// of mvm_done. It adds a per-row bias, rescales from Q(2F) to Q(F), saturates
// to DATA_WIDTH, and streams the four results over a valid/ready interface.
// A done edge that arrives while a vector is still in flight is dropped and
// flagged on the sticky overrun output.
// Optional build macro: MVM_REQUANT_ROUND_EN. When it is defined, results are
// rounded half-up before the shift instead of truncated toward minus infinity.
module mvm_requant_serializer #(
  parameter int DATA_WIDTH   = 32,
  parameter int OUTPUT_WIDTH = 64,
  parameter int FRAC_BITS    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mvm_done,
  input  logic [OUTPUT_WIDTH-1:0] acc_in1,
  input  logic [OUTPUT_WIDTH-1:0] acc_in2,
  input  logic [OUTPUT_WIDTH-1:0] acc_in3,
  input  logic [OUTPUT_WIDTH-1:0] acc_in4,
  input  logic [DATA_WIDTH-1:0]   bias1,
  input  logic [DATA_WIDTH-1:0]   bias2,
  input  logic [DATA_WIDTH-1:0]   bias3,
  input  logic [DATA_WIDTH-1:0]   bias4,
  output logic [DATA_WIDTH-1:0]   res_data,
  output logic [1:0]              res_idx,
  output logic                    res_last,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    clr_overrun
);

  // One guard bit above the accumulator width keeps the rounding add and the
  // bias add free of wrap-around.
  localparam int EW = OUTPUT_WIDTH + 1;
  localparam logic signed [EW-1:0] SAT_MAX = (EW'(1) <<< (DATA_WIDTH - 1)) - EW'(1);
  localparam logic signed [EW-1:0] SAT_MIN = -(EW'(1) <<< (DATA_WIDTH - 1));
`ifdef MVM_REQUANT_ROUND_EN
  localparam logic signed [EW-1:0] RND_HALF = EW'(1) <<< (FRAC_BITS - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SEND
  } state_t;

  state_t r_state;
  logic   r_done_q;
  logic   r_armed;
  logic   r_valid;
  logic   r_last;
  logic   r_busy;
  logic   r_overrun;
  logic [1:0]            r_idx;
  logic [DATA_WIDTH-1:0] r_data;

  logic [OUTPUT_WIDTH-1:0] r_acc  [4];
  logic [DATA_WIDTH-1:0]   r_bias [4];
  logic [DATA_WIDTH-1:0]   r_buf  [4];

  logic [OUTPUT_WIDTH-1:0] w_acc_in  [4];
  logic [DATA_WIDTH-1:0]   w_bias_in [4];
  logic [DATA_WIDTH-1:0]   w_sat     [4];
  logic w_done_rise;
  logic w_capture;
  logic w_overrun_evt;

  assign w_acc_in[0]  = acc_in1;
  assign w_acc_in[1]  = acc_in2;
  assign w_acc_in[2]  = acc_in3;
  assign w_acc_in[3]  = acc_in4;
  assign w_bias_in[0] = bias1;
  assign w_bias_in[1] = bias2;
  assign w_bias_in[2] = bias3;
  assign w_bias_in[3] = bias4;

  // r_armed stays low after reset until mvm_done has been seen low. A done
  // level that is still high when reset releases is therefore not taken as a
  // fresh completion. The edge register itself still resets to zero.
  assign w_done_rise   = mvm_done & ~r_done_q & r_armed;
  assign w_capture     = w_done_rise && (r_state == S_IDLE);
  assign w_overrun_evt = w_done_rise && (r_state != S_IDLE);

  assign res_data  = r_data;
  assign res_idx   = r_idx;
  assign res_last  = r_last;
  assign res_valid = r_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

  // Per-row requantisation: shift, add the bias, then clamp to DATA_WIDTH.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      logic signed [EW-1:0] w_ext;
      logic signed [EW-1:0] w_pre;
      logic signed [EW-1:0] w_shr;
      logic signed [EW-1:0] w_bias_ext;
      logic signed [EW-1:0] w_sum;

      assign w_ext      = {r_acc[gi][OUTPUT_WIDTH-1], r_acc[gi]};
`ifdef MVM_REQUANT_ROUND_EN
      assign w_pre      = w_ext + RND_HALF;
`else
      assign w_pre      = w_ext;
`endif
      assign w_shr      = w_pre >>> FRAC_BITS;
      assign w_bias_ext = {{(EW - DATA_WIDTH){r_bias[gi][DATA_WIDTH-1]}}, r_bias[gi]};
      assign w_sum      = w_shr + w_bias_ext;
      assign w_sat[gi]  = (w_sum > SAT_MAX) ? SAT_MAX[DATA_WIDTH-1:0] :
                          (w_sum < SAT_MIN) ? SAT_MIN[DATA_WIDTH-1:0] :
                          w_sum[DATA_WIDTH-1:0];
    end
  endgenerate

  // Datapath storage: capture operands when idle, fill the result buffer in CALC.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_capture) begin
        r_acc[i]  <= w_acc_in[i];
        r_bias[i] <= w_bias_in[i];
      end
      if (r_state == S_CALC) begin
        r_buf[i] <= w_sat[i];
      end
    end
  end

  // Control FSM with registered stream outputs, done-edge tracking and overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_done_q  <= 1'b0;
      r_armed   <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_idx     <= 2'd0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done_q <= mvm_done;
      if (!mvm_done) begin
        r_armed <= 1'b1;
      end

      // A set takes priority over a coinciding clear.
      if (w_overrun_evt) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_capture) begin
            r_state <= S_CALC;
            r_busy  <= 1'b1;
          end
        end
        S_CALC: begin
          r_state <= S_SEND;
        end
        S_SEND: begin
          // The first SEND cycle only presents beat 0. That separates the
          // buffer write from the first valid beat.
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_data  <= r_buf[0];
            r_idx   <= 2'd0;
            r_last  <= 1'b0;
          end else if (res_ready) begin
            if (r_idx == 2'd3) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
            end else begin
              r_idx  <= r_idx + 2'd1;
              r_data <= r_buf[r_idx + 2'd1];
              r_last <= (r_idx == 2'd2);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_requant_serializer.sv
// Testbench for mvm_requant_serializer. A queue-based model predicts every
// beat, the busy and overrun flags, and the valid timing. The model is checked
// against the DUT on every falling clock edge. Directed scenarios pin the
// model with literal values, then a randomized phase follows.
module tb_mvm_requant_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mvm_done;
  logic [63:0] acc  [4];
  logic [31:0] bias [4];
  logic [31:0] res_data;
  logic [1:0]  res_idx;
  logic        res_last;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        overrun;
  logic        clr_overrun;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  idx;
  } beat_t;

  beat_t       exp_q [$];
  logic [31:0] got_q [$];
  logic        m_prev;
  logic        m_armed;
  logic        m_ovr;
  int          m_age;
  logic        rr_en = 1'b0;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  always #5 clk = ~clk;

  mvm_requant_serializer dut (
    .clk(clk), .rst(rst), .mvm_done(mvm_done),
    .acc_in1(acc[0]), .acc_in2(acc[1]), .acc_in3(acc[2]), .acc_in4(acc[3]),
    .bias1(bias[0]), .bias2(bias[1]), .bias3(bias[2]), .bias4(bias[3]),
    .res_data(res_data), .res_idx(res_idx), .res_last(res_last),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  // Value-level reference: floor division by 2^16 (optionally rounded), plus
  // the bias, then a clamp to the signed 32-bit range.
  function automatic logic [31:0] requant(input logic [63:0] a_in, input logic [31:0] b_in);
    longint a, q, s;
    a = a_in;
    q = a >>> 16;
`ifdef MVM_REQUANT_ROUND_EN
    if (a_in[15]) q = q + 1;
`endif
    s = q + longint'($signed(b_in));
    if (s > SMAX) return 32'h7FFF_FFFF;
    if (s < SMIN) return 32'h8000_0000;
    return s[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Compare the DUT with the model, then advance the model to the next rising edge.
  always @(negedge clk) begin : mon
    logic  ev;
    logic  rise;
    beat_t nb;
    if (rst) begin
      check("rst_valid", 64'(res_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
      check("rst_data", 64'(res_data), 64'd0);
      check("rst_idx_last", 64'({res_idx, res_last}), 64'd0);
      exp_q.delete();
      m_prev  = 1'b0;
      m_armed = 1'b0;
      m_ovr   = 1'b0;
      m_age   = 100;
    end else begin
      ev = (exp_q.size() != 0) && (m_age >= 2);
      check("valid", 64'(res_valid), 64'(ev));
      check("busy", 64'(busy), 64'(exp_q.size() != 0));
      check("overrun", 64'(overrun), 64'(m_ovr));
      if (ev && res_valid) begin
        check("data", 64'(res_data), 64'(exp_q[0].data));
        check("idx", 64'(res_idx), 64'(exp_q[0].idx));
        check("last", 64'(res_last), 64'(exp_q[0].idx == 2'd3));
      end
      // Advance the model to the next rising edge.
      if (m_age < 100) m_age++;
      rise = mvm_done && !m_prev && m_armed;
      if (!mvm_done) m_armed = 1'b1;
      m_prev = mvm_done;
      if (rise && exp_q.size() != 0) m_ovr = 1'b1;
      else if (clr_overrun) m_ovr = 1'b0;
      if (ev && res_ready) begin
        got_q.push_back(res_data);
        void'(exp_q.pop_front());
      end
      if (rise && exp_q.size() == 0 && !(ev && res_ready)) begin
        for (int r = 0; r < 4; r++) begin
          nb.data = requant(acc[r], bias[r]);
          nb.idx  = 2'(r);
          exp_q.push_back(nb);
        end
        m_age = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rr_en) begin
        res_ready   = ($urandom_range(0, 3) != 0);
        clr_overrun = ($urandom_range(0, 15) == 0);
      end
    end
  endtask

  task automatic pulse_done();
    mvm_done = 1'b1;
    tick(1);
    mvm_done = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while ((busy || exp_q.size() != 0) && c < maxc) begin
      tick(1);
      c++;
    end
    check("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic wait_beat(input logic [1:0] idx, input int maxc);
    int c = 0;
    while (!(res_valid && res_idx == idx) && c < maxc) begin
      tick(1);
      c++;
    end
    check("beat_reached", 64'(res_valid && res_idx == idx), 64'd1);
  endtask

  function automatic logic [63:0] pick_acc();
    case ($urandom_range(0, 3))
      0: return {$urandom, $urandom};
      1: return 64'(longint'($signed($urandom)) <<< $urandom_range(0, 31));
      2: return 64'(longint'($signed($urandom)) <<< $urandom_range(32, 48));
      default: begin
        case ($urandom_range(0, 4))
          0: return 64'h7FFF_FFFF_FFFF_FFFF;
          1: return 64'h8000_0000_0000_0000;
          2: return 64'hFFFF_FFFF_FFFF_FFFF;
          3: return 64'h0000_0000_0000_8000;
          default: return 64'hFFFF_FFFF_FFFF_8000;
        endcase
      end
    endcase
  endfunction

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, total %0d", n_total);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; mvm_done = 1'b0; res_ready = 1'b1; clr_overrun = 1'b0;
    for (int r = 0; r < 4; r++) begin acc[r] = '0; bias[r] = '0; end
    tick(3);
    rst = 1'b0;
    tick(2);

    // Literal pins for the reference function.
    check("pin_basic", 64'(requant(64'h0000_0003_0000_0000, 32'h0001_0000)), 64'h0004_0000);
    check("pin_sat_pos", 64'(requant(64'h7FFF_FFFF_FFFF_FFFF, 32'h0)), 64'h7FFF_FFFF);
    check("pin_sat_neg", 64'(requant(64'h8000_0000_0000_0000, 32'h0)), 64'h8000_0000);
    check("pin_sat_bias", 64'(requant(64'h0000_7FFF_0000_0000, 32'h7FFF_0000)), 64'h7FFF_FFFF);
`ifdef MVM_REQUANT_ROUND_EN
    check("pin_half", 64'(requant(64'h8000, 32'h0)), 64'h1);
    check("pin_m1", 64'(requant(64'hFFFF_FFFF_FFFF_FFFF, 32'h0)), 64'h0);
`else
    check("pin_half", 64'(requant(64'h8000, 32'h0)), 64'h0);
    check("pin_m1", 64'(requant(64'hFFFF_FFFF_FFFF_FFFF, 32'h0)), 64'hFFFF_FFFF);
`endif

    // Basic: four beats of 4.0.
    for (int r = 0; r < 4; r++) begin acc[r] = 64'h0000_0003_0000_0000; bias[r] = 32'h0001_0000; end
    got_q.delete();
    pulse_done();
    wait_idle(50);
    check("basic_cnt", 64'(got_q.size()), 64'd4);
    for (int r = 0; r < 4 && r < got_q.size(); r++) check("basic_val", 64'(got_q[r]), 64'h0004_0000);

    // Saturation.
    acc[0] = 64'h7FFF_FFFF_FFFF_FFFF; acc[1] = 64'h8000_0000_0000_0000;
    acc[2] = 64'h0000_7FFF_0000_0000; acc[3] = 64'h0;
    bias[0] = 32'h0; bias[1] = 32'h0; bias[2] = 32'h7FFF_0000; bias[3] = 32'h0;
    got_q.delete();
    pulse_done();
    wait_idle(50);
    check("sat_cnt", 64'(got_q.size()), 64'd4);
    if (got_q.size() >= 3) begin
      check("sat_row1", 64'(got_q[0]), 64'h7FFF_FFFF);
      check("sat_row2", 64'(got_q[1]), 64'h8000_0000);
      check("sat_row3", 64'(got_q[2]), 64'h7FFF_FFFF);
    end

    // Rounding behaviour.
    acc[0] = 64'h8000; acc[1] = 64'hFFFF_FFFF_FFFF_FFFF; acc[2] = 64'h8000; acc[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int r = 0; r < 4; r++) bias[r] = 32'h0;
    got_q.delete();
    pulse_done();
    wait_idle(50);
    check("rnd_cnt", 64'(got_q.size()), 64'd4);
    if (got_q.size() >= 2) begin
`ifdef MVM_REQUANT_ROUND_EN
      check("rnd_half", 64'(got_q[0]), 64'h1);
      check("rnd_m1", 64'(got_q[1]), 64'h0);
`else
      check("rnd_half", 64'(got_q[0]), 64'h0);
      check("rnd_m1", 64'(got_q[1]), 64'hFFFF_FFFF);
`endif
    end

    // Backpressure on beat 1 for five cycles.
    for (int r = 0; r < 4; r++) begin acc[r] = pick_acc(); bias[r] = $urandom; end
    got_q.delete();
    pulse_done();
    wait_beat(2'd1, 20);
    res_ready = 1'b0;
    tick(5);
    check("bp_busy", 64'(busy), 64'd1);
    check("bp_idx", 64'(res_idx), 64'd1);
    res_ready = 1'b1;
    wait_idle(50);
    check("bp_cnt", 64'(got_q.size()), 64'd4);

    // Overrun: a second vector arrives during SEND.
    for (int r = 0; r < 4; r++) begin acc[r] = 64'h0000_0003_0000_0000; bias[r] = 32'h0; end
    res_ready = 1'b0;
    got_q.delete();
    pulse_done();
    tick(3);
    for (int r = 0; r < 4; r++) acc[r] = 64'h0000_0005_0000_0000;
    pulse_done();
    check("ovr_set", 64'(overrun), 64'd1);
    check("ovr_keep_data", 64'(res_data), 64'h0003_0000);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;
    check("ovr_clr", 64'(overrun), 64'd0);
    mvm_done = 1'b1; clr_overrun = 1'b1;
    tick(1);
    mvm_done = 1'b0; clr_overrun = 1'b0;
    check("ovr_set_wins", 64'(overrun), 64'd1);
    res_ready = 1'b1;
    wait_idle(50);
    check("ovr_cnt", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) check("ovr_first_vec", 64'(got_q[3]), 64'h0003_0000);
    clr_overrun = 1'b1;
    tick(1);
    clr_overrun = 1'b0;

    // Reset during SEND idx 2.
    for (int r = 0; r < 4; r++) begin acc[r] = pick_acc(); bias[r] = $urandom; end
    pulse_done();
    wait_beat(2'd2, 20);
    res_ready = 1'b0;
    pulse_done();
    check("rst_pre_ovr", 64'(overrun), 64'd1);
    rst = 1'b1;
    #1;
    check("arst_valid", 64'(res_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_overrun", 64'(overrun), 64'd0);
    mvm_done = 1'b1;
    res_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(5);
    check("held_done_no_cap", 64'(busy), 64'd0);
    mvm_done = 1'b0;
    tick(1);
    got_q.delete();
    pulse_done();
    wait_idle(50);
    check("post_rst_cnt", 64'(got_q.size()), 64'd4);

    // Randomized phase: random data, ready, clears, hold lengths and gaps.
    rr_en = 1'b1;
    for (int v = 0; v < 40; v++) begin
      for (int r = 0; r < 4; r++) begin acc[r] = pick_acc(); bias[r] = $urandom; end
      mvm_done = 1'b1;
      tick($urandom_range(1, 3));
      mvm_done = 1'b0;
      tick($urandom_range(1, 10));
    end
    rr_en = 1'b0;
    res_ready = 1'b1;
    clr_overrun = 1'b0;
    wait_idle(100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
